// File: rtl/trace_block_expander.sv
// trace_block_expander
// ---------------------
// Re-expands one compressed trace block (start address, halfwords retired,
// last-instruction size, itype/cause/tval, privilege) into one entry per
// retired instruction, one entry per cycle. Instruction sizes come from a
// combinational program-image lookup driven by img_addr_o.
//
// Ports:
//   clk_i, rst_ni        clock, asynchronous active-low reset
//   blk_*_i / blk_ready_o block input handshake and fields
//   img_addr_o           image lookup address (current pc)
//   img_compressed_i     lookup answer: instruction at img_addr_o is 16-bit
//   out_*                per-instruction entry stream (valid/ready)
//   err_o                one-cycle pulse on a size inconsistency (fire cycle)

package mure_pkg;
  localparam int XLEN        = 32;
  localparam int IRETIRE_LEN = 14;
  localparam int ITYPE_LEN   = 4;
  localparam int CAUSE_LEN   = 5;
  localparam int PRIV_LEN    = 2;
endpackage

module trace_block_expander #(
  parameter bit CHECK_LASTSIZE = 1'b1
) (
  input  logic                             clk_i,
  input  logic                             rst_ni,
  input  logic                             blk_valid_i,
  output logic                             blk_ready_o,
  input  logic [mure_pkg::XLEN-1:0]        blk_iaddr_i,
  input  logic [mure_pkg::IRETIRE_LEN-1:0] blk_iretire_i,
  input  logic                             blk_ilastsize_i,
  input  logic [mure_pkg::ITYPE_LEN-1:0]   blk_itype_i,
  input  logic [mure_pkg::CAUSE_LEN-1:0]   blk_cause_i,
  input  logic [mure_pkg::XLEN-1:0]        blk_tval_i,
  input  logic [mure_pkg::PRIV_LEN-1:0]    blk_priv_i,
  output logic [mure_pkg::XLEN-1:0]        img_addr_o,
  input  logic                             img_compressed_i,
  output logic                             out_valid_o,
  input  logic                             out_ready_i,
  output logic [mure_pkg::XLEN-1:0]        out_pc_o,
  output logic                             out_compressed_o,
  output logic                             out_retired_o,
  output logic                             out_last_o,
  output logic [mure_pkg::ITYPE_LEN-1:0]   out_itype_o,
  output logic [mure_pkg::CAUSE_LEN-1:0]   out_cause_o,
  output logic [mure_pkg::XLEN-1:0]        out_tval_o,
  output logic [mure_pkg::PRIV_LEN-1:0]    out_priv_o,
  output logic                             err_o
);

  localparam int XL = mure_pkg::XLEN;
  localparam int RL = mure_pkg::IRETIRE_LEN;
  localparam int TL = mure_pkg::ITYPE_LEN;
  localparam int CL = mure_pkg::CAUSE_LEN;
  localparam int PL = mure_pkg::PRIV_LEN;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_EXPAND = 2'd1,
    S_EVENT  = 2'd2
  } state_e;

  state_e        state_q, state_d;
  logic [XL-1:0] pc_q, pc_d;
  logic [RL-1:0] rem_q, rem_d;
  logic          ilastsize_q, ilastsize_d;
  logic [TL-1:0] itype_q, itype_d;
  logic [CL-1:0] cause_q, cause_d;
  logic [XL-1:0] tval_q, tval_d;
  logic [PL-1:0] priv_q, priv_d;

  logic [RL-1:0] hw_s;        // halfwords of the current instruction
  logic [XL-1:0] step_s;      // byte step to the next pc
  logic          last_s;      // current EXPAND entry ends the block
  logic          overrun_s;   // instruction is larger than what remains
  logic          size_err_s;  // decoded size disagrees with ilastsize
  logic          blk_fire_s;
  logic          out_fire_s;

  // Size of the instruction at the current pc and the block-end decisions.
  always_comb begin
    hw_s       = img_compressed_i ? {{(RL-1){1'b0}}, 1'b1} : {{(RL-2){1'b0}}, 2'b10};
    step_s     = img_compressed_i ? {{(XL-2){1'b0}}, 2'b10} : {{(XL-3){1'b0}}, 3'b100};
    last_s     = (hw_s >= rem_q);
    overrun_s  = (hw_s > rem_q);
    // ilastsize=1 means the last instruction is 32-bit, so equality with
    // the compressed flag is the inconsistent case.
    size_err_s = CHECK_LASTSIZE && (img_compressed_i == ilastsize_q);
  end

  // Output decode; everything is zero while idle.
  always_comb begin
    blk_ready_o      = 1'b0;
    img_addr_o       = '0;
    out_valid_o      = 1'b0;
    out_pc_o         = '0;
    out_compressed_o = 1'b0;
    out_retired_o    = 1'b0;
    out_last_o       = 1'b0;
    out_itype_o      = '0;
    out_cause_o      = '0;
    out_tval_o       = '0;
    out_priv_o       = '0;
    case (state_q)
      S_IDLE: begin
        blk_ready_o = 1'b1;
      end
      S_EXPAND: begin
        img_addr_o       = pc_q;
        out_valid_o      = 1'b1;
        out_pc_o         = pc_q;
        out_compressed_o = img_compressed_i;
        out_retired_o    = 1'b1;
        out_last_o       = last_s;
        out_priv_o       = priv_q;
        if (last_s) begin
          out_itype_o = itype_q;
          out_cause_o = cause_q;
          out_tval_o  = tval_q;
        end else begin
          out_itype_o = '0;
          out_cause_o = '0;
          out_tval_o  = '0;
        end
      end
      S_EVENT: begin
        img_addr_o  = pc_q;
        out_valid_o = 1'b1;
        out_pc_o    = pc_q;
        out_last_o  = 1'b1;
        out_itype_o = itype_q;
        out_cause_o = cause_q;
        out_tval_o  = tval_q;
        out_priv_o  = priv_q;
      end
      default: begin
        blk_ready_o = 1'b0;
      end
    endcase
  end

  // Handshakes and the error pulse, which only exists on an accepted entry.
  always_comb begin
    blk_fire_s = blk_valid_i && (state_q == S_IDLE);
    out_fire_s = out_valid_o && out_ready_i;
    if ((state_q == S_EXPAND) && out_fire_s && last_s) begin
      err_o = overrun_s || size_err_s;
    end else begin
      err_o = 1'b0;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    rem_d       = rem_q;
    ilastsize_d = ilastsize_q;
    itype_d     = itype_q;
    cause_d     = cause_q;
    tval_d      = tval_q;
    priv_d      = priv_q;
    case (state_q)
      S_IDLE: begin
        if (blk_fire_s) begin
          pc_d        = blk_iaddr_i;
          rem_d       = blk_iretire_i;
          ilastsize_d = blk_ilastsize_i;
          itype_d     = blk_itype_i;
          cause_d     = blk_cause_i;
          tval_d      = blk_tval_i;
          priv_d      = blk_priv_i;
          state_d     = (blk_iretire_i != {RL{1'b0}}) ? S_EXPAND : S_EVENT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_EXPAND: begin
        if (out_fire_s) begin
          pc_d = pc_q + step_s;
          if (last_s) begin
            // Overrun also lands here: the block is simply terminated.
            rem_d   = '0;
            state_d = S_IDLE;
          end else begin
            rem_d   = rem_q - hw_s;
            state_d = S_EXPAND;
          end
        end else begin
          state_d = S_EXPAND;
        end
      end
      S_EVENT: begin
        if (out_fire_s) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_EVENT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and block registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= S_IDLE;
      pc_q        <= '0;
      rem_q       <= '0;
      ilastsize_q <= 1'b0;
      itype_q     <= '0;
      cause_q     <= '0;
      tval_q      <= '0;
      priv_q      <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      rem_q       <= rem_d;
      ilastsize_q <= ilastsize_d;
      itype_q     <= itype_d;
      cause_q     <= cause_d;
      tval_q      <= tval_d;
      priv_q      <= priv_d;
    end
  end

endmodule

// File: tb/tb_trace_block_expander.sv
module tb_trace_block_expander;

  typedef struct {
    logic [31:0] iaddr;
    logic [13:0] iretire;
    logic        ilast;
    logic [3:0]  itype;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
  } blk_t;

  typedef struct {
    logic [31:0] pc;
    logic        c;
    logic        ret;
    logic        last;
    logic [3:0]  itype;
    logic [4:0]  cause;
    logic [31:0] tval;
    logic [1:0]  priv;
    logic        err;
    logic        err_nc;
  } ent_t;

  typedef struct {
    blk_t        b;
    logic [31:0] base;
    logic [63:0] bits;
    int          n;
    logic [31:0] last_pc;
    int          errs;
    int          errs_nc;
  } vec_t;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        blk_valid_i;
  logic [31:0] blk_iaddr_i;
  logic [13:0] blk_iretire_i;
  logic        blk_ilastsize_i;
  logic [3:0]  blk_itype_i;
  logic [4:0]  blk_cause_i;
  logic [31:0] blk_tval_i;
  logic [1:0]  blk_priv_i;
  logic        out_ready_i;

  logic        blk_ready_o, out_valid_o, out_compressed_o, out_retired_o, out_last_o, err_o;
  logic [31:0] img_addr_o, out_pc_o, out_tval_o;
  logic [3:0]  out_itype_o;
  logic [4:0]  out_cause_o;
  logic [1:0]  out_priv_o;
  logic        img_c;

  logic        n_blk_ready, n_out_valid, n_out_c, n_out_ret, n_out_last, n_err;
  logic [31:0] n_img_addr, n_out_pc, n_out_tval;
  logic [3:0]  n_out_itype;
  logic [4:0]  n_out_cause;
  logic [1:0]  n_out_priv;
  logic        n_img_c;

  // Program image: a 64-halfword table region, else a fixed address hash.
  logic [31:0] img_base;
  logic [63:0] img_bits;
  logic        img_tab_en;

  int n_cmp = 0;
  int n_bad = 0;
  ent_t got_q[$];
  ent_t exp_q[$];

  always #5 clk_i = ~clk_i;

  function automatic logic img_lookup(input logic [31:0] a);
    logic [31:0] off;
    off = a - img_base;
    if (img_tab_en && (off < 32'd128)) return img_bits[off[6:1]];
    return a[2] ^ a[5] ^ a[9];
  endfunction

  always_comb img_c = img_lookup(img_addr_o);
  always_comb n_img_c = img_lookup(n_img_addr);

  trace_block_expander #(.CHECK_LASTSIZE(1'b1)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .blk_valid_i(blk_valid_i), .blk_ready_o(blk_ready_o),
    .blk_iaddr_i(blk_iaddr_i), .blk_iretire_i(blk_iretire_i),
    .blk_ilastsize_i(blk_ilastsize_i), .blk_itype_i(blk_itype_i),
    .blk_cause_i(blk_cause_i), .blk_tval_i(blk_tval_i), .blk_priv_i(blk_priv_i),
    .img_addr_o(img_addr_o), .img_compressed_i(img_c),
    .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_pc_o(out_pc_o), .out_compressed_o(out_compressed_o),
    .out_retired_o(out_retired_o), .out_last_o(out_last_o),
    .out_itype_o(out_itype_o), .out_cause_o(out_cause_o),
    .out_tval_o(out_tval_o), .out_priv_o(out_priv_o), .err_o(err_o)
  );

  trace_block_expander #(.CHECK_LASTSIZE(1'b0)) dut_nc (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .blk_valid_i(blk_valid_i), .blk_ready_o(n_blk_ready),
    .blk_iaddr_i(blk_iaddr_i), .blk_iretire_i(blk_iretire_i),
    .blk_ilastsize_i(blk_ilastsize_i), .blk_itype_i(blk_itype_i),
    .blk_cause_i(blk_cause_i), .blk_tval_i(blk_tval_i), .blk_priv_i(blk_priv_i),
    .img_addr_o(n_img_addr), .img_compressed_i(n_img_c),
    .out_valid_o(n_out_valid), .out_ready_i(out_ready_i),
    .out_pc_o(n_out_pc), .out_compressed_o(n_out_c),
    .out_retired_o(n_out_ret), .out_last_o(n_out_last),
    .out_itype_o(n_out_itype), .out_cause_o(n_out_cause),
    .out_tval_o(n_out_tval), .out_priv_o(n_out_priv), .err_o(n_err)
  );

  function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endfunction

  // Reference: walk the block halfword budget through the image.
  function automatic void model(input blk_t b);
    ent_t e;
    logic [31:0] pc;
    int rem, hw;
    exp_q.delete();
    if (b.iretire == 14'd0) begin
      e = '{b.iaddr, 1'b0, 1'b0, 1'b1, b.itype, b.cause, b.tval, b.priv, 1'b0, 1'b0};
      exp_q.push_back(e);
      return;
    end
    pc = b.iaddr;
    rem = int'(b.iretire);
    forever begin
      e.pc = pc;
      e.c = img_lookup(pc);
      hw = e.c ? 1 : 2;
      e.ret = 1'b1;
      e.last = (hw >= rem);
      e.itype = e.last ? b.itype : 4'd0;
      e.cause = e.last ? b.cause : 5'd0;
      e.tval = e.last ? b.tval : 32'd0;
      e.priv = b.priv;
      e.err_nc = e.last && (hw > rem);
      e.err = e.last && ((hw > rem) || (e.c == b.ilast));
      exp_q.push_back(e);
      if (e.last) break;
      pc = pc + 32'(2 * hw);
      rem = rem - hw;
    end
  endfunction

  task automatic send_block(input blk_t b);
    int n;
    n = 0;
    @(negedge clk_i);
    while (!blk_ready_o && n < 50) begin
      @(negedge clk_i);
      n++;
    end
    chk("blk_ready_before_send", 64'(blk_ready_o), 64'd1);
    blk_iaddr_i = b.iaddr;
    blk_iretire_i = b.iretire;
    blk_ilastsize_i = b.ilast;
    blk_itype_i = b.itype;
    blk_cause_i = b.cause;
    blk_tval_i = b.tval;
    blk_priv_i = b.priv;
    blk_valid_i = 1'b1;
    @(posedge clk_i);
  endtask

  // Gather entries; stall_idx/stall_len hold ready low on one entry.
  task automatic collect(input int stall_idx, input int stall_len, input bit rand_rdy, output int stalls);
    ent_t e;
    int idx, st;
    bit done;
    idx = 0; st = 0; done = 0; stalls = 0;
    got_q.delete();
    for (int cyc = 0; cyc < 300 && !done; cyc++) begin
      @(negedge clk_i);
      blk_valid_i = 1'b0;
      if (idx == stall_idx && st < stall_len) out_ready_i = 1'b0;
      else if (rand_rdy) out_ready_i = ($urandom_range(0, 3) != 0);
      else out_ready_i = 1'b1;
      #1;
      if (out_valid_o) begin
        e = '{out_pc_o, out_compressed_o, out_retired_o, out_last_o, out_itype_o,
              out_cause_o, out_tval_o, out_priv_o, err_o, n_err};
        if (out_ready_i) begin
          got_q.push_back(e);
          idx++;
          if (e.last) done = 1;
        end else begin
          stalls++;
          if (idx == stall_idx) st++;
          chk("stall_err", 64'(err_o), 64'd0);
          chk("stall_err_nc", 64'(n_err), 64'd0);
          if (idx < exp_q.size()) begin
            chk("stall_pc", 64'(e.pc), 64'(exp_q[idx].pc));
            chk("stall_last", 64'(e.last), 64'(exp_q[idx].last));
          end
        end
      end
    end
    if (!done) chk("collect_timeout", 64'd0, 64'd1);
  endtask

  task automatic compare_all(input string tag);
    chk({tag, "_n_entries"}, 64'(got_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < got_q.size() && i < exp_q.size(); i++) begin
      chk($sformatf("%s[%0d].pc", tag, i), 64'(got_q[i].pc), 64'(exp_q[i].pc));
      chk($sformatf("%s[%0d].c", tag, i), 64'(got_q[i].c), 64'(exp_q[i].c));
      chk($sformatf("%s[%0d].ret", tag, i), 64'(got_q[i].ret), 64'(exp_q[i].ret));
      chk($sformatf("%s[%0d].last", tag, i), 64'(got_q[i].last), 64'(exp_q[i].last));
      chk($sformatf("%s[%0d].itype", tag, i), 64'(got_q[i].itype), 64'(exp_q[i].itype));
      chk($sformatf("%s[%0d].cause", tag, i), 64'(got_q[i].cause), 64'(exp_q[i].cause));
      chk($sformatf("%s[%0d].tval", tag, i), 64'(got_q[i].tval), 64'(exp_q[i].tval));
      chk($sformatf("%s[%0d].priv", tag, i), 64'(got_q[i].priv), 64'(exp_q[i].priv));
      chk($sformatf("%s[%0d].err", tag, i), 64'(got_q[i].err), 64'(exp_q[i].err));
      chk($sformatf("%s[%0d].err_nc", tag, i), 64'(got_q[i].err_nc), 64'(exp_q[i].err_nc));
    end
  endtask

  initial begin
    vec_t vt[7];
    blk_t b1, b;
    int stalls, es, ens;

    vt[0] = '{'{32'h8000_0000, 14'd5, 1'b1, 4'd3, 5'd0, 32'h0, 2'd3}, 32'h8000_0000, 64'h1, 3, 32'h8000_0006, 0, 0};
    vt[1] = '{'{32'h0000_0100, 14'd0, 1'b0, 4'd1, 5'd2, 32'hDEAD, 2'd0}, 32'h0, 64'h0, 1, 32'h0000_0100, 0, 0};
    vt[2] = '{'{32'h0000_0200, 14'd3, 1'b1, 4'd0, 5'd0, 32'h0, 2'd1}, 32'h200, 64'h0, 2, 32'h0000_0204, 1, 1};
    vt[3] = '{'{32'h0000_0300, 14'd2, 1'b1, 4'd2, 5'd5, 32'h1234, 2'd3}, 32'h300, 64'h3, 2, 32'h0000_0302, 1, 0};
    vt[4] = '{'{32'h0000_0400, 14'd4, 1'b0, 4'd4, 5'd7, 32'h55, 2'd2}, 32'h400, 64'hF, 4, 32'h0000_0406, 0, 0};
    vt[5] = '{'{32'h0000_0500, 14'd2, 1'b0, 4'd5, 5'd1, 32'h77, 2'd1}, 32'h500, 64'h0, 1, 32'h0000_0500, 1, 0};
    vt[6] = '{'{32'hFFFF_FFFE, 14'd3, 1'b1, 4'd3, 5'd3, 32'h9, 2'd0}, 32'hFFFF_FFFE, 64'h0, 2, 32'h0000_0002, 1, 1};

    rst_ni = 1'b0;
    blk_valid_i = 1'b0;
    blk_iaddr_i = '0; blk_iretire_i = '0; blk_ilastsize_i = 1'b0;
    blk_itype_i = '0; blk_cause_i = '0; blk_tval_i = '0; blk_priv_i = '0;
    out_ready_i = 1'b1;
    img_base = 32'h0; img_bits = 64'h0; img_tab_en = 1'b1;
    #1;
    chk("rst_blk_ready", 64'(blk_ready_o), 64'd1);
    chk("rst_out_valid", 64'(out_valid_o), 64'd0);
    chk("rst_out_pc", 64'(out_pc_o), 64'd0);
    chk("rst_img_addr", 64'(img_addr_o), 64'd0);
    chk("rst_err", 64'(err_o), 64'd0);
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Block 1 by hand: per-entry constants, then ready again afterwards.
    b1 = vt[0].b;
    img_base = vt[0].base; img_bits = vt[0].bits;
    model(b1);
    send_block(b1);
    collect(-1, 0, 1'b0, stalls);
    chk("t1_n", 64'(got_q.size()), 64'd3);
    if (got_q.size() == 3) begin
      chk("t1_pc0", 64'(got_q[0].pc), 64'h8000_0000);
      chk("t1_c0", 64'(got_q[0].c), 64'd1);
      chk("t1_itype0", 64'(got_q[0].itype), 64'd0);
      chk("t1_pc1", 64'(got_q[1].pc), 64'h8000_0002);
      chk("t1_c1", 64'(got_q[1].c), 64'd0);
      chk("t1_itype1", 64'(got_q[1].itype), 64'd0);
      chk("t1_pc2", 64'(got_q[2].pc), 64'h8000_0006);
      chk("t1_last2", 64'(got_q[2].last), 64'd1);
      chk("t1_itype2", 64'(got_q[2].itype), 64'd3);
      for (int i = 0; i < 3; i++) begin
        chk("t1_priv", 64'(got_q[i].priv), 64'd3);
        chk("t1_err", 64'(got_q[i].err), 64'd0);
      end
    end
    @(negedge clk_i);
    #1;
    chk("t1_ready_after", 64'(blk_ready_o), 64'd1);
    chk("t1_valid_after", 64'(out_valid_o), 64'd0);

    // Same block with three stall cycles on the second entry.
    send_block(b1);
    collect(1, 3, 1'b0, stalls);
    chk("stall_cycles", 64'(stalls), 64'd3);
    compare_all("stall");

    // Table of blocks with hand-computed summaries.
    for (int v = 0; v < 7; v++) begin
      img_base = vt[v].base; img_bits = vt[v].bits;
      model(vt[v].b);
      send_block(vt[v].b);
      collect(-1, 0, 1'b0, stalls);
      compare_all($sformatf("vec%0d", v));
      chk($sformatf("vec%0d_n", v), 64'(got_q.size()), 64'(vt[v].n));
      if (got_q.size() > 0)
        chk($sformatf("vec%0d_last_pc", v), 64'(got_q[got_q.size()-1].pc), 64'(vt[v].last_pc));
      es = 0; ens = 0;
      foreach (got_q[i]) begin
        es += int'(got_q[i].err);
        ens += int'(got_q[i].err_nc);
      end
      chk($sformatf("vec%0d_errs", v), 64'(es), 64'(vt[v].errs));
      chk($sformatf("vec%0d_errs_nc", v), 64'(ens), 64'(vt[v].errs_nc));
    end

    // Reset in the middle of block 1, then a fresh block.
    img_base = vt[0].base; img_bits = vt[0].bits;
    send_block(b1);
    @(negedge clk_i);
    blk_valid_i = 1'b0;
    out_ready_i = 1'b1;
    #1;
    chk("mid_pc0", 64'(out_pc_o), 64'h8000_0000);
    @(negedge clk_i);
    #1;
    chk("mid_pc1", 64'(out_pc_o), 64'h8000_0002);
    rst_ni = 1'b0;
    #1;
    chk("mid_rst_valid", 64'(out_valid_o), 64'd0);
    chk("mid_rst_ready", 64'(blk_ready_o), 64'd1);
    chk("mid_rst_err", 64'(err_o), 64'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    img_base = vt[3].base; img_bits = vt[3].bits;
    model(vt[3].b);
    send_block(vt[3].b);
    collect(-1, 0, 1'b0, stalls);
    compare_all("post_rst");

    // Random blocks over a hashed image with random backpressure.
    img_tab_en = 1'b0;
    for (int r = 0; r < 40; r++) begin
      b.iaddr = $urandom() & 32'hFFFF_FFFE;
      b.iretire = ($urandom_range(0, 5) == 0) ? 14'd0 : 14'($urandom_range(1, 12));
      b.ilast = 1'($urandom_range(0, 1));
      b.itype = 4'($urandom_range(0, 15));
      b.cause = 5'($urandom_range(0, 31));
      b.tval = $urandom();
      b.priv = 2'($urandom_range(0, 3));
      model(b);
      send_block(b);
      collect(-1, 0, 1'b1, stalls);
      compare_all($sformatf("rnd%0d", r));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
